// File: rtl/gpr_commit.sv
// gpr_commit -- retirement stage for a single-issue RISC-V core.
//
// This block accepts one retiring instruction per cycle and holds the
// architectural register file (x1..x31, x0 is hard-wired zero). It publishes
// the commit pc, the retired-instruction counter and a full register snapshot
// for an external reference model. Retiring an ebreak moves the block through
// a single DRAIN cycle, which pulses is_break. It then settles in HALTED until
// the next reset.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   wb_valid / wb_ready     retirement handshake (fire = valid && ready)
//   wb_pc, wb_wen, wb_rd,   retiring instruction: pc, write enable,
//   wb_wdata, wb_ebreak     destination, write data, ebreak flag
//   rs1_addr/rs1_data,      two combinational read ports (stored state only,
//   rs2_addr/rs2_data       no bypass from the writeback inputs)
//   rf_0 .. rf_31           register snapshot
//   commit_pc, commit_valid pc of last retirement; one-cycle commit pulse
//   is_break, halted        one-cycle halt pulse (DRAIN); halted level
//   instret                 64-bit retired-instruction counter (wraps)
module gpr_commit #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wdata,
  input  logic             wb_ebreak,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  rf_0,  output logic [XLEN-1:0] rf_1,
  output logic [XLEN-1:0]  rf_2,  output logic [XLEN-1:0] rf_3,
  output logic [XLEN-1:0]  rf_4,  output logic [XLEN-1:0] rf_5,
  output logic [XLEN-1:0]  rf_6,  output logic [XLEN-1:0] rf_7,
  output logic [XLEN-1:0]  rf_8,  output logic [XLEN-1:0] rf_9,
  output logic [XLEN-1:0]  rf_10, output logic [XLEN-1:0] rf_11,
  output logic [XLEN-1:0]  rf_12, output logic [XLEN-1:0] rf_13,
  output logic [XLEN-1:0]  rf_14, output logic [XLEN-1:0] rf_15,
  output logic [XLEN-1:0]  rf_16, output logic [XLEN-1:0] rf_17,
  output logic [XLEN-1:0]  rf_18, output logic [XLEN-1:0] rf_19,
  output logic [XLEN-1:0]  rf_20, output logic [XLEN-1:0] rf_21,
  output logic [XLEN-1:0]  rf_22, output logic [XLEN-1:0] rf_23,
  output logic [XLEN-1:0]  rf_24, output logic [XLEN-1:0] rf_25,
  output logic [XLEN-1:0]  rf_26, output logic [XLEN-1:0] rf_27,
  output logic [XLEN-1:0]  rf_28, output logic [XLEN-1:0] rf_29,
  output logic [XLEN-1:0]  rf_30, output logic [XLEN-1:0] rf_31,
  output logic [XLEN-1:0]  commit_pc,
  output logic             commit_valid,
  output logic             is_break,
  output logic             halted,
  output logic [63:0]      instret
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_regs [1:31];
  logic [XLEN-1:0]    r_commit_pc;
  logic               r_commit_valid;
  logic               r_is_break;
  logic               r_halted;
  logic [63:0]        r_instret;

  logic               w_fire;
  logic [XLEN-1:0]    w_rf [32];

  // Ready is only asserted in RUN. That makes wb_valid a no-op in DRAIN/HALTED.
  assign wb_ready = (r_state == S_RUN);
  assign w_fire   = wb_valid && wb_ready;

  // Flat view of the register file with x0 pinned to zero. Both the read
  // ports and the snapshot outputs use it.
  assign w_rf[0] = '0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_rf_view
      assign w_rf[gi] = r_regs[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < 32; k++) begin
        r_regs[k] <= '0;
      end
      r_commit_pc    <= RESET_PC;
      r_commit_valid <= 1'b0;
      r_is_break     <= 1'b0;
      r_halted       <= 1'b0;
      r_instret      <= '0;
      r_state        <= S_RUN;
    end else begin
      r_commit_valid <= w_fire;
      r_is_break     <= 1'b0;
      if (w_fire) begin
        r_commit_pc <= wb_pc;
        r_instret   <= r_instret + 64'd1;
        if (wb_wen && (wb_rd != 5'd0)) begin
          r_regs[wb_rd] <= wb_wdata;
        end
      end
      case (r_state)
        S_RUN: begin
          // The ebreak retires normally this edge. is_break lines up with
          // its commit_valid pulse during DRAIN.
          if (w_fire && wb_ebreak) begin
            r_state    <= S_DRAIN;
            r_is_break <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_HALTED;
        end
      endcase
    end
  end

  // Reads come from stored state only, so a same-cycle write becomes visible
  // on the next cycle.
  assign rs1_data = w_rf[rs1_addr];
  assign rs2_data = w_rf[rs2_addr];

  assign commit_pc    = r_commit_pc;
  assign commit_valid = r_commit_valid;
  assign is_break     = r_is_break;
  assign halted       = r_halted;
  assign instret      = r_instret;

  assign rf_0  = w_rf[0];  assign rf_1  = w_rf[1];
  assign rf_2  = w_rf[2];  assign rf_3  = w_rf[3];
  assign rf_4  = w_rf[4];  assign rf_5  = w_rf[5];
  assign rf_6  = w_rf[6];  assign rf_7  = w_rf[7];
  assign rf_8  = w_rf[8];  assign rf_9  = w_rf[9];
  assign rf_10 = w_rf[10]; assign rf_11 = w_rf[11];
  assign rf_12 = w_rf[12]; assign rf_13 = w_rf[13];
  assign rf_14 = w_rf[14]; assign rf_15 = w_rf[15];
  assign rf_16 = w_rf[16]; assign rf_17 = w_rf[17];
  assign rf_18 = w_rf[18]; assign rf_19 = w_rf[19];
  assign rf_20 = w_rf[20]; assign rf_21 = w_rf[21];
  assign rf_22 = w_rf[22]; assign rf_23 = w_rf[23];
  assign rf_24 = w_rf[24]; assign rf_25 = w_rf[25];
  assign rf_26 = w_rf[26]; assign rf_27 = w_rf[27];
  assign rf_28 = w_rf[28]; assign rf_29 = w_rf[29];
  assign rf_30 = w_rf[30]; assign rf_31 = w_rf[31];

endmodule

// File: tb/tb_gpr_commit.sv
module tb_gpr_commit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [63:0] wb_pc = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_wdata = '0;
  logic        wb_ebreak = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [63:0] rs1_data, rs2_data;
  logic [63:0] rf_w [32];
  logic [63:0] commit_pc;
  logic        commit_valid, is_break, halted;
  logic [63:0] instret;

  always #5 clk = ~clk;

  gpr_commit #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_ebreak(wb_ebreak),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rf_0(rf_w[0]),   .rf_1(rf_w[1]),   .rf_2(rf_w[2]),   .rf_3(rf_w[3]),
    .rf_4(rf_w[4]),   .rf_5(rf_w[5]),   .rf_6(rf_w[6]),   .rf_7(rf_w[7]),
    .rf_8(rf_w[8]),   .rf_9(rf_w[9]),   .rf_10(rf_w[10]), .rf_11(rf_w[11]),
    .rf_12(rf_w[12]), .rf_13(rf_w[13]), .rf_14(rf_w[14]), .rf_15(rf_w[15]),
    .rf_16(rf_w[16]), .rf_17(rf_w[17]), .rf_18(rf_w[18]), .rf_19(rf_w[19]),
    .rf_20(rf_w[20]), .rf_21(rf_w[21]), .rf_22(rf_w[22]), .rf_23(rf_w[23]),
    .rf_24(rf_w[24]), .rf_25(rf_w[25]), .rf_26(rf_w[26]), .rf_27(rf_w[27]),
    .rf_28(rf_w[28]), .rf_29(rf_w[29]), .rf_30(rf_w[30]), .rf_31(rf_w[31]),
    .commit_pc(commit_pc), .commit_valid(commit_valid),
    .is_break(is_break), .halted(halted), .instret(instret)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] cnt;
    logic [4:0]  rd;
    logic [63:0] rdval;
    logic        brk;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] model_rf [32];
  logic [63:0] model_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) model_rf[k] = '0;
    model_instret = '0;
  endtask

  // Sets up a retirement at the negedge and records its expected commit.
  task automatic drive_fire(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                            input logic [63:0] wdata, input logic brk);
    exp_t e;
    @(negedge clk);
    wb_valid = 1'b1; wb_pc = pc; wb_wen = wen; wb_rd = rd;
    wb_wdata = wdata; wb_ebreak = brk;
    if (wen && rd != 5'd0) model_rf[rd] = wdata;
    model_instret = model_instret + 64'd1;
    e.pc = pc; e.cnt = model_instret; e.rd = rd; e.rdval = model_rf[rd]; e.brk = brk;
    sb_q.push_back(e);
  endtask

  task automatic end_fire();
    @(posedge clk);
    #1;
    wb_valid = 1'b0; wb_ebreak = 1'b0; wb_wen = 1'b0;
  endtask

  task automatic fire(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                      input logic [63:0] wdata, input logic brk);
    drive_fire(pc, wen, rd, wdata, brk);
    end_fire();
  endtask

  // Monitor: each commit_valid pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_commit: got commit_pc %h required no commit", commit_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_instret", instret, e.cnt);
          chk($sformatf("commit_rf_%0d", e.rd), rf_w[e.rd], e.rdval);
          chk("commit_is_break", {63'd0, is_break}, {63'd0, e.brk});
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    // Reset state
    chk("rst_ready", {63'd0, wb_ready}, 64'd1);
    chk("rst_commit_pc", commit_pc, 64'h8000_0000);
    chk("rst_instret", instret, 64'd0);
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_rf_5", rf_w[5], 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic write to x5
    fire(64'h8000_0000, 1'b1, 5'd5, 64'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("commit_valid_drop", {63'd0, commit_valid}, 64'd0);

    // Write to x0 is dropped
    rs1_addr = 5'd0;
    fire(64'h8000_0004, 1'b1, 5'd0, 64'hFFFF, 1'b0);
    @(negedge clk);
    chk("x0_rs1_data", rs1_data, 64'd0);
    chk("x0_rf_0", rf_w[0], 64'd0);

    // wen=0 writes nothing
    fire(64'h8000_0008, 1'b0, 5'd3, 64'hDEAD, 1'b0);
    @(negedge clk);
    chk("nowen_rf_3", rf_w[3], 64'd0);

    // Read-before-write on x7
    fire(64'h8000_000C, 1'b1, 5'd7, 64'h11, 1'b0);
    rs1_addr = 5'd7; rs2_addr = 5'd5;
    drive_fire(64'h8000_0010, 1'b1, 5'd7, 64'hAA, 1'b0);
    #1;
    chk("rbw_old_rs1", rs1_data, 64'h11);
    chk("rbw_rs2", rs2_data, 64'h1234);
    end_fire();
    @(negedge clk);
    chk("rbw_new_rs1", rs1_data, 64'hAA);

    // Idle ebreak without valid has no effect
    wb_ebreak = 1'b1;
    @(negedge clk); @(negedge clk);
    wb_ebreak = 1'b0;
    chk("idle_brk_ready", {63'd0, wb_ready}, 64'd1);
    chk("idle_brk_instret", instret, model_instret);

    // Counter wrap
    @(negedge clk);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    fire(64'h8000_0014, 1'b0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("wrap_zero", instret, 64'd0);

    // ebreak: x10 set nonzero first so the zero write is observable
    fire(64'h8000_0018, 1'b1, 5'd10, 64'h55, 1'b0);
    fire(64'h8000_0010, 1'b1, 5'd10, 64'd0, 1'b1);
    @(negedge clk);
    chk("drain_ready", {63'd0, wb_ready}, 64'd0);
    chk("drain_halted", {63'd0, halted}, 64'd0);
    @(negedge clk);
    chk("halt_is_break", {63'd0, is_break}, 64'd0);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd1; wb_wdata = 64'h77; wb_pc = 64'h9000_0000;
    @(negedge clk); @(negedge clk);
    wb_valid = 1'b0; wb_wen = 1'b0;
    chk("halt_rf_1", rf_w[1], 64'd0);
    chk("halt_instret", instret, model_instret);
    chk("halt_commit_pc", commit_pc, 64'h8000_0010);
    chk("halt_commit_valid", {63'd0, commit_valid}, 64'd0);

    // Reset during DRAIN takes effect before the next clock edge
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    fire(64'h8000_0020, 1'b1, 5'd5, 64'h99, 1'b1);
    @(negedge clk);
    chk("pre_rst_is_break", {63'd0, is_break}, 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("async_is_break", {63'd0, is_break}, 64'd0);
    chk("async_halted", {63'd0, halted}, 64'd0);
    chk("async_rf_5", rf_w[5], 64'd0);
    chk("async_commit_pc", commit_pc, 64'h8000_0000);
    chk("async_instret", instret, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    #1;
    chk("rel_ready", {63'd0, wb_ready}, 64'd1);
    fire(64'h8000_0000, 1'b1, 5'd6, 64'hCAFE, 1'b0);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: got %0d pending commits required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_commit.md
GPR_COMMIT -- requirements
Module: gpr_commit

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/pc width.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, commit_pc value after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  writeback holds a retiring instruction.
REQ-006 SHALL have port wb_ready  output  1  block accepts retirement this cycle.
REQ-007 SHALL have port wb_pc  input  XLEN  pc of retiring instruction.
REQ-008 SHALL have port wb_wen  input  1  retiring instruction writes rd.
REQ-009 SHALL have port wb_rd  input  5  destination register index.
REQ-010 SHALL have port wb_wdata  input  XLEN  destination write data.
REQ-011 SHALL have port wb_ebreak  input  1  retiring instruction is ebreak.
REQ-012 SHALL have ports rs1_addr, rs2_addr  input  5  each, read indices.
REQ-013 SHALL have ports rs1_data, rs2_data  output  XLEN  each, read data.
REQ-014 SHALL have ports rf_0 .. rf_31  output  XLEN  each, architectural register snapshot for the DPI/difftest model.
REQ-015 SHALL have port commit_pc  output  XLEN  pc of last retired instruction.
REQ-016 SHALL have port commit_valid  output  1  one-cycle pulse, a retirement completed on the previous edge.
REQ-017 SHALL have port is_break  output  1  one-cycle halt pulse to the DPI model.
REQ-018 SHALL have port halted  output  1  core stopped, level.
REQ-019 SHALL have port instret  output  64  retired-instruction counter.

Function
REQ-020 SHALL treat a retirement as accepted ("fire") iff wb_valid && wb_ready at a rising edge.
REQ-021 SHALL drive wb_ready = 1 only in state RUN; 0 in DRAIN and HALTED.
REQ-022 SHALL on fire with wb_wen=1 and wb_rd!=0 write wb_wdata into register wb_rd at that edge; wb_wen=0 or wb_rd=0 SHALL write nothing.
REQ-023 SHALL hold x0 at 0 permanently; rf_0 and reads of index 0 SHALL return 0.
REQ-024 SHALL return rsN_data combinationally from stored state (read-before-write); a same-cycle write to the read index SHALL be visible only from the next cycle; no bypass path from wb_* to rs*_data.
REQ-025 SHALL on fire load commit_pc <= wb_pc, set commit_valid = 1 for the following cycle only, and increment instret by 1, wrapping 2^64-1 -> 0.
REQ-026 SHALL drive rf_k = stored register k continuously, updated the cycle after the write.
REQ-027 SHALL implement FSM RUN -> DRAIN on fire with wb_ebreak=1; DRAIN -> HALTED unconditionally after one cycle; HALTED held until reset.
REQ-028 SHALL perform the ebreak retirement fully (write, commit_pc, instret, commit_valid) before halting.
REQ-029 SHALL assert is_break = 1 exactly during the DRAIN cycle, aligned with commit_valid of the ebreak, so rf_* and commit_pc already reflect the ebreak.
REQ-030 SHALL assert halted = 1 in HALTED only; wb_valid in DRAIN/HALTED SHALL have no effect on any state.
REQ-031 SHALL ignore wb_ebreak when wb_valid=0.

Reset
REQ-032 SHALL on rst_n=0, immediately and independent of clk: all 31 registers 0, commit_pc=RESET_PC, instret=0, commit_valid=0, is_break=0, halted=0, state RUN.
REQ-033 SHALL abandon any in-flight retirement or DRAIN/HALTED when reset asserts mid-operation; first fire after rst_n rises SHALL behave as from power-up.

Verification
REQ-034 SHALL pass: fire pc=0x80000000, wen=1, rd=5, wdata=0x1234 -> next cycle rf_5=0x1234, commit_pc=0x80000000, commit_valid=1 one cycle, instret=1.
REQ-035 SHALL pass: fire wen=1, rd=0, wdata=0xFFFF, with rs1_addr=0 -> rf_0=0, rs1_data=0, instret increments.
REQ-036 SHALL pass: fire rd=7 wdata=0xAA while rs1_addr=7 (old 0x11) -> rs1_data=0x11 that cycle, 0xAA next cycle.
REQ-037 SHALL pass: fire wb_ebreak=1, wen=1, rd=10, wdata=0 at pc=0x80000010 -> next cycle is_break=1, rf_10=0, commit_pc=0x80000010, wb_ready=0; following cycle is_break=0, halted=1; later wb_valid pulses change nothing.
REQ-038 SHALL pass: instret preloaded/driven to 2^64-1 then one fire -> instret=0.
REQ-039 SHALL pass: rst_n low between edges during DRAIN -> is_break=0, halted=0, rf_*=0, commit_pc=0x80000000 before next clk edge; wb_ready=1 after release.
